// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: merges two register-file write streams (ALU and load
// writeback), each buffered in its own FIFO, with a read port. Each cycle
// one bank operation (READ, WRITE or IDLE) is decided and presented on
// registered outputs. Reads are held back while they hit a queued write.
module reg_write_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wa_valid,
  output logic        wa_ready,
  input  logic [3:0]  wa_addr,
  input  logic [31:0] wa_data,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        rd_req,
  input  logic [3:0]  rd_addr1,
  input  logic [3:0]  rd_addr2,
  output logic        rd_grant,
  output logic [3:0]  bank_r1,
  output logic [3:0]  bank_r2,
  output logic [3:0]  bank_r3,
  output logic        bank_rw,
  output logic [31:0] bank_w_in,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_e;

  // True when slot idx holds a queued entry (lies within count of the head)
  function automatic logic entry_live(input logic [AW-1:0] idx,
                                      input logic [AW-1:0] rptr,
                                      input logic [CW-1:0] cnt);
    logic [AW-1:0] off;
    off = idx - rptr;
    return ({1'b0, off} < cnt);
  endfunction

  // True when a queued address collides with a nonzero read address
  function automatic logic addr_hit(input logic [3:0] entry,
                                    input logic [3:0] a1,
                                    input logic [3:0] a2);
    return ((a1 != 4'd0) && (entry == a1)) || ((a2 != 4'd0) && (entry == a2));
  endfunction

  // Index 0 is requester A, index 1 is requester B
  logic [3:0]    addr_q [2][DEPTH];
  logic [3:0]    addr_d [2][DEPTH];
  logic [31:0]   data_q [2][DEPTH];
  logic [31:0]   data_d [2][DEPTH];
  logic [AW-1:0] wptr_q [2];
  logic [AW-1:0] wptr_d [2];
  logic [AW-1:0] rptr_q [2];
  logic [AW-1:0] rptr_d [2];
  logic [CW-1:0] cnt_q  [2];
  logic [CW-1:0] cnt_d  [2];
  logic          rr_q, rr_d;          // preferred FIFO when both non-empty
  logic          bank_rw_q, bank_rw_d;
  logic          rd_grant_q, rd_grant_d;
  logic [3:0]    bank_r1_q, bank_r1_d;
  logic [3:0]    bank_r2_q, bank_r2_d;
  logic [3:0]    bank_r3_q, bank_r3_d;
  logic [31:0]   bank_w_in_q, bank_w_in_d;

  logic [1:0]    full_s, nempty_s, push_s, pop_s;
  logic [3:0]    in_addr_s [2];
  logic [31:0]   in_data_s [2];
  logic          in_valid_s [2];
  logic          hazard_s, sel_s;
  op_e           op_s;

  assign in_addr_s[0]  = wa_addr;
  assign in_addr_s[1]  = wb_addr;
  assign in_data_s[0]  = wa_data;
  assign in_data_s[1]  = wb_data;
  assign in_valid_s[0] = wa_valid;
  assign in_valid_s[1] = wb_valid;

  assign full_s[0]   = (cnt_q[0] == CNT_FULL);
  assign full_s[1]   = (cnt_q[1] == CNT_FULL);
  assign nempty_s[0] = (cnt_q[0] != CNT_ZERO);
  assign nempty_s[1] = (cnt_q[1] != CNT_ZERO);

  assign wa_ready  = ~full_s[0];
  assign wb_ready  = ~full_s[1];
  assign busy      = |nempty_s;
  assign bank_rw   = bank_rw_q;
  assign rd_grant  = rd_grant_q;
  assign bank_r1   = bank_r1_q;
  assign bank_r2   = bank_r2_q;
  assign bank_r3   = bank_r3_q;
  assign bank_w_in = bank_w_in_q;

  // Next-state: hazard scan, operation decision, FIFO push/pop and outputs
  always_comb begin
    addr_d      = addr_q;
    data_d      = data_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    bank_rw_d   = 1'b0;
    rd_grant_d  = 1'b0;
    bank_r1_d   = bank_r1_q;
    bank_r2_d   = bank_r2_q;
    bank_r3_d   = bank_r3_q;
    bank_w_in_d = bank_w_in_q;
    push_s      = 2'b00;
    pop_s       = 2'b00;
    hazard_s    = 1'b0;
    sel_s       = 1'b0;

    // Only entries already stored count; same-edge enqueues are not visible
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        hazard_s = hazard_s |
                   (entry_live(AW'(i), rptr_q[k], cnt_q[k]) &
                    addr_hit(addr_q[k][i], rd_addr1, rd_addr2));
      end
    end

    if (full_s == 2'b11) begin
      op_s = OP_WRITE;
    end else if (rd_req && !hazard_s) begin
      op_s = OP_READ;
    end else if (nempty_s != 2'b00) begin
      op_s = OP_WRITE;
    end else begin
      op_s = OP_IDLE;
    end

    // Round-robin only matters when both FIFOs have work
    if (nempty_s == 2'b11) begin
      sel_s = rr_q;
    end else begin
      sel_s = nempty_s[1];
    end

    case (op_s)
      OP_READ: begin
        rd_grant_d = 1'b1;
        bank_r1_d  = rd_addr1;
        bank_r2_d  = rd_addr2;
      end
      OP_WRITE: begin
        bank_rw_d       = 1'b1;
        bank_r3_d       = addr_q[sel_s][rptr_q[sel_s]];
        bank_w_in_d     = data_q[sel_s][rptr_q[sel_s]];
        rptr_d[sel_s]   = rptr_q[sel_s] + PTR_ONE;
        pop_s[sel_s]    = 1'b1;
        rr_d            = ~sel_s;
      end
      default: begin
        bank_rw_d  = 1'b0;
        rd_grant_d = 1'b0;
      end
    endcase

    // Writes to R0 complete the handshake but are never stored
    for (int k = 0; k < 2; k++) begin
      push_s[k] = in_valid_s[k] && !full_s[k] && (in_addr_s[k] != 4'd0);
      if (push_s[k]) begin
        addr_d[k][wptr_q[k]] = in_addr_s[k];
        data_d[k][wptr_q[k]] = in_data_s[k];
        wptr_d[k]            = wptr_q[k] + PTR_ONE;
      end else begin
        wptr_d[k] = wptr_q[k];
      end
      case ({push_s[k], pop_s[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + CNT_ONE;
        2'b01:   cnt_d[k] = cnt_q[k] - CNT_ONE;
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  // State registers; reset drops every queued write at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < DEPTH; i++) begin
          addr_q[k][i] <= 4'd0;
          data_q[k][i] <= 32'd0;
        end
        wptr_q[k] <= {AW{1'b0}};
        rptr_q[k] <= {AW{1'b0}};
        cnt_q[k]  <= CNT_ZERO;
      end
      rr_q        <= 1'b0;
      bank_rw_q   <= 1'b0;
      rd_grant_q  <= 1'b0;
      bank_r1_q   <= 4'd0;
      bank_r2_q   <= 4'd0;
      bank_r3_q   <= 4'd0;
      bank_w_in_q <= 32'd0;
    end else begin
      addr_q      <= addr_d;
      data_q      <= data_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      bank_rw_q   <= bank_rw_d;
      rd_grant_q  <= rd_grant_d;
      bank_r1_q   <= bank_r1_d;
      bank_r2_q   <= bank_r2_d;
      bank_r3_q   <= bank_r3_d;
      bank_w_in_q <= bank_w_in_d;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_reg_write_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        wa_valid, wa_ready, wb_valid, wb_ready;
  logic [3:0]  wa_addr, wb_addr;
  logic [31:0] wa_data, wb_data;
  logic        rd_req, rd_grant;
  logic [3:0]  rd_addr1, rd_addr2;
  logic [3:0]  bank_r1, bank_r2, bank_r3;
  logic        bank_rw, busy;
  logic [31:0] bank_w_in;

  reg_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_req(rd_req), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_grant(rd_grant),
    .bank_r1(bank_r1), .bank_r2(bank_r2), .bank_r3(bank_r3),
    .bank_rw(bank_rw), .bank_w_in(bank_w_in), .busy(busy)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per requester plus expected output registers
  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } ent_t;
  ent_t        qa[$];
  ent_t        qb[$];
  bit          pref_b;
  logic        m_rw, m_grant;
  logic [3:0]  m_r1, m_r2, m_r3;
  logic [31:0] m_w;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    qa.delete();
    qb.delete();
    pref_b  = 1'b0;
    m_rw    = 1'b0;
    m_grant = 1'b0;
    m_r1    = 4'd0;
    m_r2    = 4'd0;
    m_r3    = 4'd0;
    m_w     = 32'd0;
  endtask

  function automatic bit hits(input logic [3:0] a);
    return ((rd_addr1 != 4'd0) && (a == rd_addr1)) || ((rd_addr2 != 4'd0) && (a == rd_addr2));
  endfunction

  // Inputs are set; predict this edge, clock it, compare all outputs
  task automatic step();
    bit   hz, pa, pb, take_b;
    ent_t e;
    check_val("wa_ready", wa_ready, qa.size() < DEPTH);
    check_val("wb_ready", wb_ready, qb.size() < DEPTH);
    check_val("busy", busy, (qa.size() + qb.size()) != 0);
    hz = 1'b0;
    foreach (qa[i]) if (hits(qa[i].addr)) hz = 1'b1;
    foreach (qb[i]) if (hits(qb[i].addr)) hz = 1'b1;
    pa = wa_valid && (qa.size() < DEPTH);
    pb = wb_valid && (qb.size() < DEPTH);
    m_rw    = 1'b0;
    m_grant = 1'b0;
    if ((qa.size() == DEPTH && qb.size() == DEPTH) ||
        !(rd_req && !hz) && (qa.size() + qb.size() != 0)) begin
      if (qa.size() == 0)      take_b = 1'b1;
      else if (qb.size() == 0) take_b = 1'b0;
      else                     take_b = pref_b;
      e = take_b ? qb.pop_front() : qa.pop_front();
      pref_b = !take_b;
      m_rw = 1'b1;
      m_r3 = e.addr;
      m_w  = e.data;
    end else if (rd_req && !hz) begin
      m_grant = 1'b1;
      m_r1 = rd_addr1;
      m_r2 = rd_addr2;
    end
    if (pa && wa_addr != 4'd0) qa.push_back('{addr: wa_addr, data: wa_data});
    if (pb && wb_addr != 4'd0) qb.push_back('{addr: wb_addr, data: wb_data});
    @(posedge clk);
    #1;
    check_val("bank_rw", bank_rw, m_rw);
    check_val("rd_grant", rd_grant, m_grant);
    check_val("bank_r1", bank_r1, m_r1);
    check_val("bank_r2", bank_r2, m_r2);
    check_val("bank_r3", bank_r3, m_r3);
    check_val("bank_w_in", bank_w_in, m_w);
  endtask

  // Pulse reset away from the edge and check the outputs clear immediately
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_val("rst_bank_rw", bank_rw, 1'b0);
    check_val("rst_rd_grant", rd_grant, 1'b0);
    check_val("rst_r1", bank_r1, 4'd0);
    check_val("rst_r2", bank_r2, 4'd0);
    check_val("rst_r3", bank_r3, 4'd0);
    check_val("rst_w_in", bank_w_in, 32'd0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_wa_ready", wa_ready, 1'b1);
    check_val("rst_wb_ready", wb_ready, 1'b1);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic idle_inputs();
    wa_valid = 1'b0; wa_addr = 4'd0; wa_data = 32'd0;
    wb_valid = 1'b0; wb_addr = 4'd0; wb_data = 32'd0;
    rd_req = 1'b0; rd_addr1 = 4'd0; rd_addr2 = 4'd0;
  endtask

  logic [3:0] seq[$];
  logic [3:0] exp_seq [4];
  int         nw;

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_clear();
    #2;
    do_reset();

    // Single write then idle
    wa_valid = 1'b1; wa_addr = 4'd5; wa_data = 32'h0000_00AA;
    step();
    wa_valid = 1'b0;
    step();
    check_val("t_single_r3", bank_r3, 4'd5);
    check_val("t_single_w", bank_w_in, 32'hAA);
    step();
    check_val("t_single_busy", busy, 1'b0);

    // Read-after-write hazard: write of 3 goes first, then the read
    wa_valid = 1'b1; wa_addr = 4'd3; wa_data = 32'h11;
    step();
    wa_valid = 1'b0;
    rd_req = 1'b1; rd_addr1 = 4'd3; rd_addr2 = 4'd7;
    step();
    check_val("t_haz_write", bank_rw, 1'b1);
    check_val("t_haz_nogrant", rd_grant, 1'b0);
    step();
    check_val("t_haz_grant", rd_grant, 1'b1);
    check_val("t_haz_r1", bank_r1, 4'd3);
    check_val("t_haz_r2", bank_r2, 4'd7);
    idle_inputs();
    step();

    // Round-robin order between A and B
    do_reset();
    seq.delete();
    wa_valid = 1'b1; wa_addr = 4'd1; wa_data = 32'hA1;
    wb_valid = 1'b1; wb_addr = 4'd9; wb_data = 32'hB9;
    step();
    wa_addr = 4'd2; wa_data = 32'hA2;
    wb_addr = 4'd10; wb_data = 32'hBA;
    step();
    if (bank_rw) seq.push_back(bank_r3);
    wa_valid = 1'b0; wb_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bank_rw) seq.push_back(bank_r3);
    end
    exp_seq = '{4'd1, 4'd9, 4'd2, 4'd10};
    check_val("t_rr_count", seq.size(), 4);
    for (int i = 0; i < 4; i++)
      check_val("t_rr_seq", (i < seq.size()) ? seq[i] : 4'hF, exp_seq[i]);

    // Forced drain with both FIFOs full and a read waiting
    do_reset();
    rd_req = 1'b1; rd_addr1 = 4'd12; rd_addr2 = 4'd13;
    wa_valid = 1'b1; wa_addr = 4'd1; wb_valid = 1'b1; wb_addr = 4'd2;
    step();
    wa_addr = 4'd3; wb_addr = 4'd4;
    step();
    wa_valid = 1'b0; wb_valid = 1'b0;
    check_val("t_full_wa_ready", wa_ready, 1'b0);
    check_val("t_full_wb_ready", wb_ready, 1'b0);
    step();
    check_val("t_full_drain", bank_rw, 1'b1);
    step();
    check_val("t_full_read", rd_grant, 1'b1);
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    // Write to R0 is accepted and dropped
    do_reset();
    wb_valid = 1'b1; wb_addr = 4'd0; wb_data = 32'hDEAD;
    check_val("t_r0_ready", wb_ready, 1'b1);
    step();
    wb_valid = 1'b0;
    check_val("t_r0_busy", busy, 1'b0);
    nw = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bank_rw) nw++;
    end
    check_val("t_r0_nowrite", nw, 0);

    // Reset in the middle of a backlog discards everything
    do_reset();
    rd_req = 1'b1; rd_addr1 = 4'd14; rd_addr2 = 4'd15;
    wa_valid = 1'b1; wa_addr = 4'd1; wb_valid = 1'b1; wb_addr = 4'd9;
    step();
    wb_valid = 1'b0; wa_addr = 4'd2;
    step();
    idle_inputs();
    check_val("t_mid_busy", busy, 1'b1);
    do_reset();
    nw = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bank_rw) nw++;
    end
    check_val("t_mid_nowrite", nw, 0);

    // Random traffic; the read requester holds its request until granted
    for (int c = 0; c < 400; c++) begin
      wa_valid = 1'($urandom_range(0, 1));
      wa_addr  = 4'($urandom_range(0, 7));
      wa_data  = $urandom();
      wb_valid = 1'($urandom_range(0, 1));
      wb_addr  = 4'($urandom_range(0, 7));
      wb_data  = $urandom();
      if (!rd_req || m_grant) begin
        rd_req   = ($urandom_range(0, 2) == 0);
        rd_addr1 = 4'($urandom_range(0, 7));
        rd_addr2 = 4'($urandom_range(0, 7));
      end
      step();
      if (c == 200) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
